// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch path: word/opcode types, the HALT opcode
// and the fetch FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t OP_HALT = 6'b111111;
    localparam word_t   PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    function automatic logic is_halt(input word_t w);
        return w[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: captured words and fetch-stall cycles.
// Instantiated by fetch_unit only when FETCH_PERF_EN is defined.
import cpu_types_pkg::*;

module fetch_perf_ctr (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  cap_i,
    input  logic  stall_i,
    output word_t fetch_count_o,
    output word_t stall_cycles_o
);

    word_t fcnt_q, fcnt_d;
    word_t scnt_q, scnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        if (cap_i)   fcnt_d = fcnt_q + 32'd1;
        if (stall_i) scnt_d = scnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign fetch_count_o  = fcnt_q;
    assign stall_cycles_o = scnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: icache handshake, IF output register, HALT drain.
// Optional counters (fetch_count/stall_cycles) enabled by FETCH_PERF_EN.
import cpu_types_pkg::*;

module fetch_unit (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  flush,
    output logic  iREN,
    output logic  pcEN,
    output logic  halt,
    output word_t instr,
    output word_t npc,
    output logic  instr_valid
`ifdef FETCH_PERF_EN
   ,output word_t fetch_count,
    output word_t stall_cycles
`endif
);

    fetch_state_t state_q, state_d;
    word_t        instr_q, instr_d;
    word_t        npc_q, npc_d;
    logic         valid_q, valid_d;

    logic slot_free;
    logic cap;
    logic cap_halt;

    assign slot_free = !valid_q || !stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else if (cap) begin
                    instr_d = imemload;
                    npc_d   = imemaddr + PC_STEP;
                    valid_d = 1'b1;
                    if (cap_halt) state_d = DRAIN;
                end else if (!ihit && !stall) begin
                    valid_d = 1'b0;
                end
            end
            // The HALT word waits here until consumed or squashed.
            DRAIN: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end
            end
            HALTED: valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iREN     = 1'b0;
        pcEN     = 1'b0;
        halt     = 1'b0;
        cap      = 1'b0;
        cap_halt = 1'b0;
        unique case (state_q)
            IDLE: ;
            FETCH: begin
                iREN     = 1'b1;
                cap      = !flush && ihit && slot_free;
                cap_halt = cap && is_halt(imemload);
                pcEN     = flush || (cap && !cap_halt);
            end
            DRAIN:  pcEN = flush;
            HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign instr       = instr_q;
    assign npc         = npc_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic perf_stall;

    assign perf_stall = iREN && !pcEN && !flush;

    fetch_perf_ctr u_perf (
        .CLK            (CLK),
        .nRST           (nRST),
        .cap_i          (cap),
        .stall_i        (perf_stall),
        .fetch_count_o  (fetch_count),
        .stall_cycles_o (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, HALT/flush/reset
// sequences, and randomized traffic against a behavioural model.
import cpu_types_pkg::*;

module tb_fetch_unit;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  stall;
    logic  flush;
    logic  iREN;
    logic  pcEN;
    logic  halt;
    word_t instr;
    word_t npc;
    logic  instr_valid;
`ifdef FETCH_PERF_EN
    word_t fetch_count;
    word_t stall_cycles;
`endif

    fetch_unit dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .flush       (flush),
        .iREN        (iREN),
        .pcEN        (pcEN),
        .halt        (halt),
        .instr       (instr),
        .npc         (npc),
        .instr_valid (instr_valid)
`ifdef FETCH_PERF_EN
       ,.fetch_count (fetch_count),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the fetch path viewed as "waiting after reset",
    // "holding a HALT word", "stopped", plus one output slot.
    bit    m_boot;
    bit    m_hold_halt;
    bit    m_stopped;
    bit    m_valid;
    word_t m_instr;
    word_t m_npc;

    typedef struct {
        logic  rst;
        word_t addr;
        logic  hit;
        word_t load;
        logic  stl;
        logic  fl;
        logic  e_iren;
        logic  e_pcen;
        logic  e_halt;
        logic  e_valid;
        word_t e_instr;
        word_t e_npc;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input word_t a, input logic h,
                        input word_t l, input logic s, input logic f,
                        input logic ei, input logic ep, input logic eh,
                        input logic ev, input word_t ein, input word_t en);
        vec_t v;
        v.rst = r; v.addr = a; v.hit = h; v.load = l; v.stl = s; v.fl = f;
        v.e_iren = ei; v.e_pcen = ep; v.e_halt = eh; v.e_valid = ev;
        v.e_instr = ein; v.e_npc = en;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input word_t a, input logic h,
                         input word_t l, input logic s, input logic f);
        nRST = r; imemaddr = a; ihit = h; imemload = l; stall = s; flush = f;
    endtask

    task automatic model_edge();
        bit slot_open;
        slot_open = !m_valid || !stall;
        if (!nRST) begin
            m_boot = 1; m_hold_halt = 0; m_stopped = 0;
            m_valid = 0; m_instr = 0; m_npc = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_stopped) begin
        end else if (m_hold_halt) begin
            if (flush) begin
                m_valid = 0; m_hold_halt = 0;
            end else if (!stall) begin
                m_valid = 0; m_hold_halt = 0; m_stopped = 1;
            end
        end else if (flush) begin
            m_valid = 0;
        end else if (ihit && slot_open) begin
            m_instr = imemload;
            m_npc   = imemaddr + 32'd4;
            m_valid = 1;
            if (imemload[31:26] == 6'h3f) m_hold_halt = 1;
        end else if (!ihit && !stall) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic expect_out(input string nm, input int idx,
                              input logic ei, input logic ep, input logic eh,
                              input logic ev, input word_t ein, input word_t en);
        checks++;
        if ({iREN, pcEN, halt, instr_valid, instr, npc} !==
            {ei, ep, eh, ev, ein, en}) begin
            errors++;
            $display("FAIL %s[%0d]: got iREN=%b pcEN=%b halt=%b valid=%b instr=%h npc=%h, want iREN=%b pcEN=%b halt=%b valid=%b instr=%h npc=%h",
                     nm, idx, iREN, pcEN, halt, instr_valid, instr, npc,
                     ei, ep, eh, ev, ein, en);
        end
    endtask

    task automatic check_model(input int idx);
        bit fetching, slot_open, e_pc;
        fetching  = !m_boot && !m_hold_halt && !m_stopped;
        slot_open = !m_valid || !stall;
        e_pc = (fetching && (flush ||
                (ihit && slot_open && imemload[31:26] != 6'h3f))) ||
               (m_hold_halt && flush);
        expect_out("rand", idx, fetching, e_pc, m_stopped, m_valid,
                   m_instr, m_npc);
    endtask

    localparam word_t A0 = 32'h0000_0013;
    localparam word_t A1 = 32'h0040_0093;
    localparam word_t A2 = 32'h0081_0113;
    localparam word_t A3 = 32'h00C1_8193;
    localparam word_t A4 = 32'h1234_5678;
    localparam word_t A5 = 32'h0252_0213;
    localparam word_t A6 = 32'h0000_0EEE;
    localparam word_t A7 = 32'h0303_0313;
    localparam word_t HW = 32'hFC00_0000;
    localparam word_t HW2 = 32'hFC00_0001;

    initial begin
        word_t a, l;
        logic  r, h, s, f;

        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // rst, addr, hit, load, stall, flush | iREN pcEN halt valid instr npc
        addv(1, 32'h00, 1, A0, 0, 0, 0, 0, 0, 0, 0,  0);
        addv(1, 32'h00, 1, A0, 0, 0, 1, 1, 0, 0, 0,  0);
        addv(1, 32'h04, 1, A1, 0, 0, 1, 1, 0, 1, A0, 32'h04);
        addv(1, 32'h08, 1, A2, 1, 0, 1, 0, 0, 1, A1, 32'h08);
        addv(1, 32'h08, 1, A2, 1, 0, 1, 0, 0, 1, A1, 32'h08);
        addv(1, 32'h08, 1, A2, 1, 0, 1, 0, 0, 1, A1, 32'h08);
        addv(1, 32'h08, 1, A2, 0, 0, 1, 1, 0, 1, A1, 32'h08);
        addv(1, 32'h0C, 1, A3, 0, 0, 1, 1, 0, 1, A2, 32'h0C);
        addv(1, 32'h10, 0, A4, 0, 0, 1, 0, 0, 1, A3, 32'h10);
        addv(1, 32'h20, 1, A4, 0, 1, 1, 1, 0, 0, A3, 32'h10);
        addv(1, 32'h24, 0, A4, 0, 0, 1, 0, 0, 0, A3, 32'h10);
        addv(1, 32'hFFFF_FFFC, 1, A5, 0, 0, 1, 1, 0, 0, A3, 32'h10);
        addv(1, 32'h24, 0, A4, 0, 0, 1, 0, 0, 1, A5, 32'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].addr, tbl[i].hit, tbl[i].load,
                  tbl[i].stl, tbl[i].fl);
            @(negedge CLK);
            expect_out("vec", i, tbl[i].e_iren, tbl[i].e_pcen,
                       tbl[i].e_halt, tbl[i].e_valid, tbl[i].e_instr,
                       tbl[i].e_npc);
            tick();
        end

        // HALT fetched under stall, drained, then sticky HALTED.
        drive(1, 32'h40, 1, HW, 0, 0);
        @(negedge CLK); expect_out("halt_cap", 0, 1, 0, 0, 0, A5, 32'h00); tick();
        drive(1, 32'h44, 1, A6, 1, 0);
        @(negedge CLK); expect_out("drain", 0, 0, 0, 0, 1, HW, 32'h44); tick();
        @(negedge CLK); expect_out("drain", 1, 0, 0, 0, 1, HW, 32'h44); tick();
        drive(1, 32'h44, 1, A6, 0, 0);
        @(negedge CLK); expect_out("drain", 2, 0, 0, 0, 1, HW, 32'h44); tick();
        drive(1, 32'h44, 1, A6, 0, 1);
        @(negedge CLK); expect_out("halted", 0, 0, 0, 1, 0, HW, 32'h44); tick();
        drive(1, 32'h48, 1, A6, 1, 0);
        @(negedge CLK); expect_out("halted", 1, 0, 0, 1, 0, HW, 32'h44); tick();
        drive(0, 32'h48, 1, A6, 0, 0);
        @(negedge CLK); expect_out("halted", 2, 0, 0, 1, 0, HW, 32'h44); tick();
        drive(1, 32'h80, 0, A6, 0, 0);
        @(negedge CLK); expect_out("rst_halted", 0, 0, 0, 0, 0, 0, 0); tick();

        // HALT squashed by a flush while draining.
        drive(1, 32'h80, 1, HW2, 0, 0);
        @(negedge CLK); expect_out("halt_cap", 1, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h84, 1, A6, 1, 1);
        @(negedge CLK); expect_out("drain_flush", 0, 0, 1, 0, 1, HW2, 32'h84); tick();
        drive(1, 32'h100, 1, A7, 0, 0);
        @(negedge CLK); expect_out("resume", 0, 1, 1, 0, 0, HW2, 32'h84); tick();
        drive(1, 32'h104, 0, A6, 0, 0);
        @(negedge CLK); expect_out("resume", 1, 1, 0, 0, 1, A7, 32'h104); tick();

`ifdef FETCH_PERF_EN
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4 * i, 1, i + 1, 0, 0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 20, 1, 6, 1, 0); tick();
        end
        for (int i = 5; i < 10; i++) begin
            drive(1, 4 * i, 1, i + 1, 0, 0); tick();
        end
        @(negedge CLK);
        checks++;
        if (fetch_count !== 32'd10 || stall_cycles !== 32'd4) begin
            errors++;
            $display("FAIL perf: got fetch_count=%0d stall_cycles=%0d, want 10 and 4",
                     fetch_count, stall_cycles);
        end
        tick();
`endif

        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) != 0);
            a = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
            h = ($urandom_range(0, 3) != 0);
            l = $urandom;
            if ($urandom_range(0, 15) == 0) l[31:26] = 6'h3f;
            else if (l[31:26] == 6'h3f) l[31] = 1'b0;
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 7) == 0);
            drive(r, a, h, l, s, f);
            @(negedge CLK);
            check_model(i);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL use one clock and a synchronous active-low reset: CLK (rising edge), nRST (active-low, sampled only on the CLK rising edge).
REQ-002 Ports, one per line:
  CLK  in  1  system clock
  nRST  in  1  synchronous active-low reset
  imemaddr  in  32  current PC from the program counter block
  ihit  in  1  icache returns a valid word this cycle
  imemload  in  32  instruction word from the icache
  stall  in  1  downstream IF/ID register cannot accept
  flush  in  1  branch/jump redirect resolved; PC block loads its target on pcEN
  iREN  out  1  instruction read request to the icache
  pcEN  out  1  PC update enable to the PC block
  halt  out  1  halt to the PC block; freezes the PC
  instr  out  32  fetched instruction
  npc  out  32  imemaddr+4 of the fetched instruction
  instr_valid  out  1  instr/npc hold a valid, undelivered instruction
REQ-003 No parameters; all widths come from the shared package (word_t = 32 bits).

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DRAIN and HALTED.
REQ-005 IDLE: iREN=0, pcEN=0; unconditionally go to FETCH on the next edge.
REQ-006 FETCH: iREN=1; output slot is "free" when instr_valid=0 or stall=0.
REQ-007 FETCH, flush=1: pcEN=1 for that cycle, instr_valid<=0, and any ihit in that cycle is discarded; flush has priority over ihit and stall.
REQ-008 FETCH, ihit=1, flush=0, slot free: instr<=imemload, npc<=imemaddr+4 (mod 2^32), instr_valid<=1, pcEN=1 (same cycle, combinational).
REQ-009 FETCH, ihit=1, slot not free: pcEN=0 and iREN stays 1; the same address re-hits on a later cycle and no word is lost.
REQ-010 FETCH, ihit=0, flush=0: pcEN=0; instr_valid<=0 if stall=0, else it holds.
REQ-011 When a captured word has opcode HALT (bits 31:26 = 6'b111111), FETCH SHALL go to DRAIN and pcEN SHALL be 0 for that capture.
REQ-012 DRAIN: iREN=0, pcEN=0, and the HALT word is held. If flush=1: instr_valid<=0, pcEN=1 and go to FETCH (wrong-path halt squashed). Else if stall=0: instr_valid<=0 and go to HALTED.
REQ-013 HALTED: iREN=0, pcEN=0, halt=1 and instr_valid=0. This state is sticky; flush, ihit and stall are ignored until reset.
REQ-014 halt SHALL be 0 in every state except HALTED.
REQ-015 Fetch-to-output latency: one cycle from ihit to instr_valid. Throughput: one instruction per cycle with continuous ihit and stall=0.

Reset
REQ-016 With nRST=0 at a rising edge, the next state SHALL be IDLE, and instr=0, npc=0, instr_valid=0, halt=0. While in IDLE, iREN=0 and pcEN=0.
REQ-017 A reset in any state, including mid-DRAIN or HALTED, SHALL take effect at that same edge and discard any held instruction.

Configuration
REQ-018 Macro FETCH_PERF_EN.
  Defined: adds outputs fetch_count (32 bits, +1 per REQ-008 capture) and stall_cycles (32 bits, +1 per FETCH cycle with iREN=1 and pcEN=0 and flush=0). Both wrap at 2^32, are cleared by reset and freeze in HALTED.
  Undefined: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-019 cpu_types_pkg SHALL hold word_t, opcode_t, the HALT opcode constant and the enum fetch_state_t {IDLE, FETCH, DRAIN, HALTED}.
REQ-020 The optional counters SHALL live in sub-module fetch_perf_ctr, instantiated only under FETCH_PERF_EN; there are no other sub-modules.

Verification
REQ-021 Reset then ihit=1 every cycle, stall=0, imemaddr stepping 0x0,0x4,0x8: instr_valid from the cycle after the first hit, npc=0x4,0x8,0xC, and pcEN=1 in every FETCH cycle.
REQ-022 With instr_valid=1, hold stall=1 for 3 cycles while ihit=1: pcEN=0, instr and npc unchanged, and after stall drops the next word is captured with nothing lost or duplicated.
REQ-023 Assert flush together with ihit at imemaddr=0x20: the word is discarded, pcEN=1 for one cycle and instr_valid=0 on the next cycle.
REQ-024 Fetch 0xFC000000 at 0x40 with stall=1 for 2 cycles: DRAIN holds the word, then HALTED with halt=1, iREN=0 and pcEN=0 permanently. A later flush has no effect.
REQ-025 Fetch HALT, then assert flush in DRAIN: return to FETCH, halt stays 0 and fetching resumes. Separately, nRST=0 in HALTED gives IDLE on the next edge with all outputs at their reset values.
REQ-026 With FETCH_PERF_EN defined, 10 hits and 4 stalled hit cycles give fetch_count=10 and stall_cycles=4.
